// File: rtl/conv1_pkg.sv
// conv1_pkg: shared conv1 dimensions and the ofmap drain state encoding
package conv1_pkg;
  localparam int CONV1_CH = 64;
  localparam int CONV1_DW = 16;
  localparam int CONV1_OFMAP_PIX = 3136;
  typedef enum logic {IDLE, DRAIN} drain_state_e;
endpackage

// File: rtl/conv1_ofmap_drain_if.sv
// conv1_ofmap_drain_if: result-vector intake and output BRAM write port bundle
interface conv1_ofmap_drain_if #(
  parameter int CH = 64,
  parameter int DW = 16,
  parameter int LANES = 4,
  parameter int ADDR_W = 16
);
  logic res_v;
  logic [CH*DW-1:0] res_data;
  logic halt_req;
  logic wr_halt;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES*DW-1:0] wr_data;
  logic map_done;
  logic ovf;
  modport master (
    input res_v, res_data, wr_halt,
    output halt_req, wr_en, wr_addr, wr_data, map_done, ovf
  );
  modport slave (
    output res_v, res_data, wr_halt,
    input halt_req, wr_en, wr_addr, wr_data, map_done, ovf
  );
endinterface

// File: rtl/pingpong_slot2.sv
// pingpong_slot2: two-slot vector store with valid bits, wr/rd pointers and occupancy
module pingpong_slot2 #(
  parameter int W = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] push_data,
  input  logic pop,
  output logic rd_valid,
  output logic nxt_valid,
  output logic drop,
  output logic [1:0] occ,
  output logic [W-1:0] rd_data
);
  logic [W-1:0] mem [2];
  logic [1:0] valid;
  logic wr_ptr, rd_ptr, take;
  // when both slots are full wr_ptr == rd_ptr, so a popping slot is the one we may refill
  assign take = push && (!valid[wr_ptr] || (pop && wr_ptr == rd_ptr));
  assign drop = push && !take;
  assign rd_valid = valid[rd_ptr];
  assign nxt_valid = valid[!rd_ptr];
  assign occ = {1'b0, valid[0]} + {1'b0, valid[1]};
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= !rd_ptr;
      end
      if (take) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr <= !wr_ptr;
      end
    end
  always_ff @(posedge clk)
    if (take) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/conv1_ofmap_drain.sv
// conv1_ofmap_drain: buffers conv1 result vectors and serialises them into the ofmap BRAM
module conv1_ofmap_drain
  import conv1_pkg::*;
#(
  parameter int CH = CONV1_CH,
  parameter int DW = CONV1_DW,
  parameter int LANES = 4,
  parameter int PIX_NUM = CONV1_OFMAP_PIX,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  conv1_ofmap_drain_if.master bus
);
  localparam int BEATS = CH / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = PIX_NUM > 1 ? $clog2(PIX_NUM) : 1;
  drain_state_e state;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] pix_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic rd_valid, nxt_valid, drop, issue, last, pop, map_end;
  logic [1:0] occ;
  logic [CH*DW-1:0] rd_data;
  pingpong_slot2 #(.W(CH*DW)) u_slot (
    .clk(clk),
    .rst(rst),
    .push(bus.res_v),
    .push_data(bus.res_data),
    .pop(pop),
    .rd_valid(rd_valid),
    .nxt_valid(nxt_valid),
    .drop(drop),
    .occ(occ),
    .rd_data(rd_data)
  );
  // a valid head slot issues in the same cycle IDLE sees it, giving res_v -> wr_en in two cycles
  assign issue = rd_valid && !bus.wr_halt;
  assign last = beat_cnt == BW'(BEATS - 1);
  assign pop = issue && last;
  assign map_end = pop && pix_cnt == PW'(PIX_NUM - 1);
  assign bus.halt_req = occ == 2'd2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      pix_cnt <= '0;
      addr_cnt <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.map_done <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      state <= state == IDLE ? (rd_valid ? DRAIN : IDLE) : (pop && !nxt_valid ? IDLE : DRAIN);
      bus.wr_en <= issue;
      bus.map_done <= map_end;
      if (drop) bus.ovf <= 1'b1;
      if (issue) begin
        bus.wr_addr <= addr_cnt;
        bus.wr_data <= rd_data[int'(beat_cnt)*LANES*DW +: LANES*DW];
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        addr_cnt <= map_end ? '0 : addr_cnt + 1'b1;
        if (pop) pix_cnt <= map_end ? '0 : pix_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_conv1_ofmap_drain.sv
// tb_conv1_ofmap_drain: directed checks of capture, drain, stalls, map wrap and reset
module tb_conv1_ofmap_drain;
  localparam int CH = 64, DW = 16, LANES = 4, ADDR_W = 16, PIX = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  conv1_ofmap_drain_if #(.CH(CH), .DW(DW), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();
  conv1_ofmap_drain #(.CH(CH), .DW(DW), .LANES(LANES), .PIX_NUM(PIX), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [CH*DW-1:0] vec(input int p);
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(p*256 + k + 1);
    return v;
  endfunction
  function automatic logic [LANES*DW-1:0] beat(input int p, input int b);
    logic [LANES*DW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*DW +: DW] = DW'(p*256 + b*LANES + l + 1);
    return w;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int p);
    bus.res_v = 1'b1;
    bus.res_data = vec(p);
    tick();
    bus.res_v = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    bus.res_v = 1'b0;
    bus.res_data = '0;
    bus.wr_halt = 1'b0;
    tick();
    tick();
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_halt_req", bus.halt_req, 0);
    chk("rst_map_done", bus.map_done, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    tick();
    // single vector: first beat two cycles after res_v
    send(0);
    chk("t1_lat_n1", bus.wr_en, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_en%0d", i), bus.wr_en, 1);
      chk($sformatf("t1_addr%0d", i), bus.wr_addr, i);
      chk($sformatf("t1_data%0d", i), bus.wr_data, beat(0, i));
      chk($sformatf("t1_halt%0d", i), bus.halt_req, 0);
      if (i == 0) chk("t1_beat0", bus.wr_data, 64'h0004_0003_0002_0001);
      if (i == 15) chk("t1_beat15", bus.wr_data, 64'h0040_003f_003e_003d);
      tick();
    end
    chk("t1_end_en", bus.wr_en, 0);
    // three pixels gapless, third accepted once halt_req drops; map_done on beat 47
    do_reset();
    send(0);
    send(1);
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("t2_en%0d", i), bus.wr_en, 1);
      chk($sformatf("t2_addr%0d", i), bus.wr_addr, i);
      chk($sformatf("t2_data%0d", i), bus.wr_data, beat(i / 16, i % 16));
      chk($sformatf("t2_halt%0d", i), bus.halt_req, (i < 15 || (i > 20 && i < 31)) ? 1 : 0);
      chk($sformatf("t2_done%0d", i), bus.map_done, i == 47 ? 1 : 0);
      if (i == 20) begin
        bus.res_v = 1'b1;
        bus.res_data = vec(2);
      end
      tick();
      bus.res_v = 1'b0;
    end
    chk("t2_end_en", bus.wr_en, 0);
    chk("t2_end_done", bus.map_done, 0);
    chk("t2_ovf", bus.ovf, 0);
    // fourth pixel after map wrap starts again at address 0
    send(3);
    tick();
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("t5_addr%0d", b), bus.wr_addr, b);
      chk($sformatf("t5_data%0d", b), bus.wr_data, beat(3, b));
      chk($sformatf("t5_done%0d", b), bus.map_done, 0);
      tick();
    end
    // producer violation: vector dropped, ovf sticky, buffered pixels intact
    do_reset();
    send(0);
    send(1);
    chk("t3_halt", bus.halt_req, 1);
    send(9);
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("t3_ovf%0d", i), bus.ovf, 1);
      chk($sformatf("t3_addr%0d", i), bus.wr_addr, i);
      chk($sformatf("t3_data%0d", i), bus.wr_data, beat(i / 16, i % 16));
      tick();
    end
    chk("t3_end_en", bus.wr_en, 0);
    chk("t3_ovf_end", bus.ovf, 1);
    // wr_halt for 5 cycles at beat 7
    do_reset();
    send(0);
    tick();
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("t4_addr%0d", b), bus.wr_addr, b);
      if (b == 6) bus.wr_halt = 1'b1;
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("t4_stall_en%0d", j), bus.wr_en, 0);
      chk($sformatf("t4_stall_addr%0d", j), bus.wr_addr, 6);
      if (j == 4) bus.wr_halt = 1'b0;
      tick();
    end
    for (int b = 7; b < 16; b++) begin
      chk($sformatf("t4_en%0d", b), bus.wr_en, 1);
      chk($sformatf("t4_addr%0d", b), bus.wr_addr, b);
      chk($sformatf("t4_data%0d", b), bus.wr_data, beat(0, b));
      tick();
    end
    chk("t4_end_en", bus.wr_en, 0);
    // async reset during beat 5 with both slots full
    do_reset();
    send(0);
    send(1);
    bus.res_v = 1'b1;
    bus.res_data = vec(2);
    tick();
    bus.res_v = 1'b0;
    repeat (4) tick();
    chk("t6_pre_addr", bus.wr_addr, 5);
    chk("t6_pre_ovf", bus.ovf, 1);
    chk("t6_pre_halt", bus.halt_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_en", bus.wr_en, 0);
    chk("t6_rst_addr", bus.wr_addr, 0);
    chk("t6_rst_data", bus.wr_data, 0);
    chk("t6_rst_halt", bus.halt_req, 0);
    chk("t6_rst_ovf", bus.ovf, 0);
    chk("t6_rst_done", bus.map_done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_en", bus.wr_en, 0);
    send(4);
    chk("t6_lat_n1", bus.wr_en, 0);
    tick();
    chk("t6_en", bus.wr_en, 1);
    chk("t6_addr", bus.wr_addr, 0);
    chk("t6_data", bus.wr_data, beat(4, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
